// File: rtl/fact_accel.sv
// fact_accel: memory-mapped iterative factorial accelerator.
// Word window: 0 = N (R/W), 1 = GO (W), 2 = STATUS {busy,err,done} (R), 3 = RESULT (R).
// One multiply step per cycle; done rises one edge after the FSM settles in DONE.
module fact_accel #(
    parameter int DW    = 32,
    parameter int NW    = 4,
    parameter int N_MAX = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [1:0]    a,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OFS_N      = 2'd0;
    localparam logic [1:0] OFS_GO     = 2'd1;
    localparam logic [1:0] OFS_STATUS = 2'd2;
    localparam logic [1:0] OFS_RESULT = 2'd3;

    logic [1:0]    r_state;
    logic [NW-1:0] r_n;
    logic [NW-1:0] r_cnt;
    logic [DW-1:0] r_prod;
    logic [DW-1:0] r_result;
    logic          r_done;
    logic          r_err;

    logic          w_start;
    logic          w_n_wr;
    logic          w_n_too_big;
    logic [DW-1:0] w_mul;
    logic          w_unused_wd;

    // GO is ignored while a computation is in flight.
    assign w_start     = we && (a == OFS_GO) && wd[0] && (r_state != BUSY);
    assign w_n_wr      = we && (a == OFS_N);
    assign w_n_too_big = int'(r_n) > N_MAX;
    assign w_mul       = r_prod * DW'(r_cnt);
    assign w_unused_wd = ^wd[DW-1:NW];

    assign busy = (r_state == BUSY);
    assign done = r_done;

    // Operand register; writable at any time, the running job uses its own copy in r_cnt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n <= '0;
        end else if (w_n_wr) begin
            r_n <= wd[NW-1:0];
        end
    end

    // Control FSM and multiply datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_done <= 1'b0;
                        if (w_n_too_big) begin
                            r_err    <= 1'b1;
                            r_result <= '0;
                            r_state  <= DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_prod  <= DW'(1);
                            r_cnt   <= r_n;
                            r_state <= BUSY;
                        end
                    end else if (r_state == DONE) begin
                        // done follows arrival in DONE by one edge, for both normal and error paths
                        r_done <= 1'b1;
                    end
                end
                BUSY: begin
                    if (r_cnt <= NW'(1)) begin
                        r_result <= r_prod;
                        r_state  <= DONE;
                    end else begin
                        r_prod <= w_mul;
                        r_cnt  <= r_cnt - NW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read mux: purely combinational, no side effects; every offset defined.
    always_comb begin
        rd = '0;
        case (a)
            OFS_N:      rd = {{(DW-NW){1'b0}}, r_n};
            OFS_GO:     rd = '0;
            OFS_STATUS: rd = {{(DW-3){1'b0}}, busy, r_err, r_done};
            OFS_RESULT: rd = r_result;
            default:    rd = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_accel.sv
// Self-checking bench for fact_accel: directed scenarios then random bus traffic,
// compared every cycle against a cycle-count/factorial reference model.
module tb_fact_accel;

    localparam int DW    = 32;
    localparam int NW    = 4;
    localparam int N_MAX = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we  = 1'b0;
    logic [1:0]    a   = 2'd0;
    logic [DW-1:0] wd  = '0;
    logic [DW-1:0] rd;
    logic          busy;
    logic          done;

    always #10 clk = ~clk;

    fact_accel #(.DW(DW), .NW(NW), .N_MAX(N_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .a   (a),
        .wd  (wd),
        .rd  (rd),
        .busy(busy),
        .done(done)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: expected register contents plus cycle counters.
    int          m_n;
    int          m_left;     // remaining busy cycles
    bit          m_arm;      // done rises on the next edge
    logic [31:0] m_result;
    logic [31:0] m_pend;
    bit          m_err;
    bit          m_done;

    function automatic logic [31:0] fact(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= n; i++) p = p * i;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_left = 0; m_arm = 0; m_result = 0; m_pend = 0; m_err = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit w, input logic [1:0] aa, input logic [31:0] d);
        bit start;
        start = w && (aa == 2'd1) && d[0] && (m_left == 0);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_result = m_pend;
                m_arm    = 1;
            end
        end else if (m_arm) begin
            m_done = 1;
            m_arm  = 0;
        end
        if (start) begin
            m_done = 0;
            if (m_n > N_MAX) begin
                m_err    = 1;
                m_result = 0;
                m_arm    = 1;
            end else begin
                m_err  = 0;
                m_left = (m_n < 1) ? 1 : m_n;
                m_pend = fact(m_n);
                m_arm  = 0;
            end
        end
        if (w && aa == 2'd0) m_n = int'(d[3:0]);
    endtask

    task automatic check_all();
        logic [31:0] exp;
        chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        chk("done", {31'd0, done}, {31'd0, m_done});
        for (int k = 0; k < 4; k++) begin
            a = 2'(k);
            #1;
            case (k)
                0:       exp = 32'(m_n);
                1:       exp = 32'd0;
                2:       exp = {29'd0, (m_left > 0), m_err, m_done};
                default: exp = m_result;
            endcase
            chk($sformatf("rd[%0d]", k), rd, exp);
        end
    endtask

    task automatic step(input bit w, input logic [1:0] aa, input logic [31:0] d);
        @(negedge clk);
        we = w; a = aa; wd = d;
        @(posedge clk);
        model_edge(w, aa, d);
        #1;
        we = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'd0, 32'd0);
    endtask

    task automatic go_n(input int n);
        step(1'b1, 2'd0, 32'(n));
        step(1'b1, 2'd1, 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] aa, input logic [31:0] exp);
        a = aa;
        #1;
        chk(tag, rd, exp);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #4;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // N=5
        go_n(5);
        idle(6);
        rd_chk("res5", 2'd3, 32'd120);
        rd_chk("stat5", 2'd2, 32'h1);

        // N=12 then N=0
        go_n(12);
        idle(13);
        rd_chk("res12", 2'd3, 32'd479001600);
        rd_chk("stat12", 2'd2, 32'h1);
        go_n(0);
        idle(2);
        rd_chk("res0", 2'd3, 32'd1);

        // N=13 error, then N=4 recovers
        go_n(13);
        idle(2);
        rd_chk("stat13", 2'd2, 32'h3);
        rd_chk("res13", 2'd3, 32'd0);
        go_n(4);
        idle(5);
        rd_chk("res4", 2'd3, 32'd24);
        rd_chk("stat4", 2'd2, 32'h1);

        // N write and GO during BUSY are ignored by the run
        go_n(6);
        idle(1);
        step(1'b1, 2'd0, 32'd3);
        step(1'b1, 2'd1, 32'd1);
        idle(6);
        rd_chk("res6", 2'd3, 32'd720);
        rd_chk("n3", 2'd0, 32'd3);
        step(1'b1, 2'd1, 32'd1);
        idle(4);
        rd_chk("res3", 2'd3, 32'd6);

        // Async reset mid-computation
        go_n(10);
        idle(4);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        rd_chk("stat_rst", 2'd2, 32'h0);
        rd_chk("res_rst", 2'd3, 32'd0);

        // Random bus traffic
        repeat (400) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
